spi_master: RTL and testbench

// - SPI initiator (master) that drives frames into the design's SPI slave + single-port RAM.
// - Accepts 10-bit commands on a valid/ready interface and serializes each one on MOSI under SS_n.
// - For read-data commands (cmd_data[9:8]=2'b11) it also captures the 8-bit response on MISO.
// - SPI bit clock = clk: one bit per clk cycle, same clock domain as the slave.

---
 rtl/spi_master.sv | 150 +++++++++++++++
 tb/tb_spi_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI initiator: serializes 10-bit commands on MOSI under SS_n and captures
// the 8-bit response of read-data commands from MISO. One bit per clk cycle.
// All outputs come straight from registers.
module spi_master #(
   parameter int unsigned RD_LATENCY = 3,  // SS_n-low cycles between last MOSI bit and first MISO sample
   parameter int unsigned GAP_CYCLES = 1   // SS_n-high cycles after each frame before IDLE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [9:0] cmd_data,
   output logic       cmd_ready,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StCmd,
      StShift,
      StTail,
      StWait,
      StRecv,
      StEnd
   } state_e;

   localparam logic [3:0] ShiftLast = 4'd9;
   localparam logic [3:0] RecvLast  = 4'd7;
   localparam logic [3:0] WaitLast  = 4'(RD_LATENCY - 1);
   localparam logic [3:0] GapLast   = 4'(GAP_CYCLES - 1);

   state_e     state_q, state_d;
   logic [9:0] shreg_q, shreg_d;
   logic       rd_op_q, rd_op_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;
   logic       ss_n_q, ss_n_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       cmd_ready_q, cmd_ready_d;

   // State register and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shreg_q     <= '0;
         rd_op_q     <= 1'b0;
         cnt_q       <= '0;
         rx_q        <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         rd_op_q     <= rd_op_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         ss_n_q      <= ss_n_d;
         mosi_q      <= mosi_d;
         busy_q      <= busy_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   // Next-state logic and next values of every registered output
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      rd_op_d    = rd_op_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      case (state_q)
         StIdle: begin
            // cmd_ready is always high here, so cmd_valid alone means accept
            if (cmd_valid) begin
               state_d = StStart;
               shreg_d = cmd_data;
               rd_op_d = (cmd_data[9:8] == 2'b11);
            end
         end
         StStart: state_d = StCmd;
         StCmd:   state_d = StShift;
         StShift: begin
            if (cnt_q == ShiftLast) begin
               state_d = rd_op_q ? StWait : StTail;
            end
         end
         StTail:  state_d = StEnd;
         StWait: begin
            if (cnt_q == WaitLast) begin
               state_d = StRecv;
            end
         end
         StRecv: begin
            rx_d = {rx_q[6:0], MISO};
            if (cnt_q == RecvLast) begin
               state_d    = StEnd;
               rd_data_d  = {rx_q[6:0], MISO};
               rd_valid_d = 1'b1;
            end
         end
         StEnd: begin
            // Back-to-back frames see these GAP_CYCLES plus the IDLE accept cycle with SS_n high
            if (cnt_q == GapLast) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Per-state cycle counter restarts on every state change
      cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;

      // MOSI is computed from the state being entered so it lines up with that state
      mosi_d = 1'b0;
      if (state_d == StCmd) begin
         mosi_d = shreg_q[9];
      end else if (state_d == StShift) begin
         mosi_d  = shreg_q[9];
         shreg_d = {shreg_q[8:0], 1'b0};
      end

      ss_n_d      = (state_d == StIdle) || (state_d == StEnd);
      busy_d      = (state_d != StIdle);
      cmd_ready_d = (state_d == StIdle);
   end

   assign cmd_ready = cmd_ready_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign busy      = busy_q;
   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: a behavioural SPI slave + RAM on the bus, a
// frame-level reference model feeding scoreboard queues, and a negedge monitor.
module tb_spi_master;

   localparam int unsigned RL  = 3;
   localparam int unsigned GAP = 1;
   localparam int unsigned WrLen = 13;          // SS_n-low cycles of a write-path frame
   localparam int unsigned RdLen = 20 + RL;     // SS_n-low cycles of a read-data frame

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [9:0] cmd_data = '0;
   logic       cmd_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO = 1'b0;

   spi_master #(
      .RD_LATENCY (RL),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_data  (cmd_data),
      .cmd_ready (cmd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .busy      (busy),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Scoreboard queues: expected frames (by command) and expected read bytes
   logic [9:0] frame_q[$];
   logic [7:0] rd_q[$];

   // Reference model state (from commands) and slave model state (from MOSI)
   logic [7:0] ref_mem[256];
   logic [7:0] slv_mem[256];
   logic [7:0] ref_addr = '0;
   logic [7:0] slv_addr = '0;

   bit abort_frame = 1'b0;
   int last_gap = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: what each accepted command must produce
   task automatic model(input logic [9:0] c);
      frame_q.push_back(c);
      case (c[9:8])
         2'b00, 2'b10: ref_addr = c[7:0];
         2'b01:        ref_mem[ref_addr] = c[7:0];
         default:      rd_q.push_back(ref_mem[ref_addr]);
      endcase
   endtask

   // Monitor + slave: capture frames, drive MISO, check read results
   int          lowcnt = 0;
   int          hicnt = 0;
   logic [31:0] bits = '0;
   logic [7:0]  miso_byte = '0;
   always @(negedge clk) begin
      if (!SS_n) begin
         if (lowcnt == 0) begin
            miso_byte = slv_mem[slv_addr];
            last_gap  = hicnt;
         end
         if (lowcnt < 32) bits[lowcnt] = MOSI;
         lowcnt++;
         hicnt = 0;
      end else begin
         hicnt++;
         if (lowcnt != 0) begin
            if (!abort_frame) begin
               if (frame_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got len %0d expected no frame", lowcnt);
               end else begin
                  logic [9:0]  c;
                  logic [31:0] exp_bits;
                  logic [9:0]  d;
                  c = frame_q.pop_front();
                  exp_bits = '0;
                  exp_bits[1] = c[9];
                  for (int k = 0; k < 10; k++) exp_bits[2+k] = c[9-k];
                  check("ss_low_len", lowcnt, (c[9:8] == 2'b11) ? RdLen : WrLen);
                  check("mosi_bits", bits, exp_bits);
                  for (int k = 0; k < 10; k++) d[9-k] = bits[2+k];
                  case (d[9:8])
                     2'b00, 2'b10: slv_addr = d[7:0];
                     2'b01:        slv_mem[slv_addr] = d[7:0];
                     default:      ;
                  endcase
               end
            end
            lowcnt = 0;
            bits   = '0;
         end
      end
      // During RECV cycles present the slave byte MSB first; elsewhere drive noise
      if (!SS_n && lowcnt >= 13 + RL && lowcnt <= 20 + RL) MISO = miso_byte[20 + RL - lowcnt];
      else MISO = 1'($urandom);
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid: got rd_data %0h expected no pulse", rd_data);
         end else begin
            check("rd_data", rd_data, rd_q.pop_front());
         end
      end
   end

   // Present a command until accepted; returns #1 after the accept edge
   task automatic send(input logic [9:0] c, input bit hold);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = c;
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got cmd_ready 0 expected 1 within 300 cycles");
         cmd_valid = 1'b0;
         return;
      end
      model(c);
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((frame_q.size() != 0 || !cmd_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got %0d pending frames expected 0", frame_q.size());
      end
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'(i * 7 + 3);
         slv_mem[i] = 8'(i * 7 + 3);
      end

      // Reset held 3 cycles
      repeat (3) @(posedge clk);
      #1;
      check("rst_ss_n", SS_n, 1'b1);
      check("rst_mosi", MOSI, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Write addr: accept-to-ready edge count, accept edge counted as 1
      send(10'h0A5, 1'b0);
      check("wr_busy", busy, 1'b1);
      cnt = 1;
      while (!cmd_ready && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("wr_ready_edges", cnt, 14 + GAP);
      wait_idle();

      // Back-to-back: wr data then rd addr with cmd_valid held
      send(10'h1C3, 1'b1);
      send(10'h2C3, 1'b0);
      wait_idle();
      // SS_n stays high for the GAP cycles of END plus the IDLE accept cycle
      check("b2b_gap", last_gap, GAP + 1);
      check("slave_wr_c3", slv_mem[8'hA5], 8'hC3);

      // Read-data returning 8'h5A: write it first, then read it back
      send(10'h0C3, 1'b0);
      send(10'h15A, 1'b0);
      send(10'h2C3, 1'b0);
      send(10'h300, 1'b0);
      cnt = 1;
      while (!rd_valid && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("rd_valid_edges", cnt, 21 + RL);
      check("rd_data_5a", rd_data, 8'h5A);
      wait_idle();

      // Reset in the middle of SHIFT of a read-data frame
      send(10'h300, 1'b0);
      repeat (7) @(posedge clk);
      abort_frame = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      frame_q.delete();
      rd_q.delete();
      check("abort_ss_n", SS_n, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_rd_valid", rd_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      abort_frame = 1'b0;
      send(10'h0A5, 1'b0);
      wait_idle();

      // cmd_valid toggled with random data while busy
      send(10'h1E7, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cmd_valid = 1'($urandom);
         cmd_data  = 10'($urandom);
      end
      check("toggle_busy", busy, 1'b1);
      cmd_valid = 1'b0;
      wait_idle();

      // End-to-end: write 3C to addr 10, read it back
      send(10'h010, 1'b0);
      send(10'h13C, 1'b0);
      send(10'h210, 1'b0);
      send(10'h300, 1'b0);
      wait_idle();
      check("e2e_rd_data", rd_data, 8'h3C);

      // Randomized command stream over a small address window
      for (int i = 0; i < 60; i++) begin
         logic [1:0] op;
         logic [7:0] pl;
         op = 2'($urandom);
         pl = (op == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 7));
         send({op, pl}, (i != 59) && ($urandom_range(0, 3) == 0));
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("rd_q_drained", rd_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
